// File: rtl/fadd_sub_arb_pkg.sv
// Shared types for the fadd_sub round-robin arbiter.
package fadd_sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/fadd_sub.sv
// Combinational FP add/subtract: truncating, denormals flushed to zero, overflow to infinity.
module fadd_sub #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1
) (
    input  logic [I_DATA-1:0] a,
    input  logic [I_DATA-1:0] b,
    input  logic              sub,
    output logic [I_DATA-1:0] result
);
    // hidden bit + mantissa + 3 guard bits; sum carries one extra bit on top
    localparam int W    = I_MNT + 4;
    localparam int EMAX = (1 << I_EXP) - 1;

    logic             sa, sb, sx, sy;
    logic [I_EXP-1:0] ea, eb, ex, ey;
    logic [W-1:0]     ma, mb, mx, my;
    logic [W:0]       sum, norm;
    logic             found;
    int               d, lz, e_res;

    always_comb begin
        sa = a[I_DATA-1];
        sb = b[I_DATA-1] ^ sub;
        ea = a[I_DATA-2 -: I_EXP];
        eb = b[I_DATA-2 -: I_EXP];
        ma = (ea == '0) ? '0 : {1'b1, a[I_MNT-1:0], 3'b000};
        mb = (eb == '0) ? '0 : {1'b1, b[I_MNT-1:0], 3'b000};

        if ({ea, ma} >= {eb, mb}) begin
            sx = sa; ex = ea; mx = ma;
            sy = sb; ey = eb; my = mb;
        end else begin
            sx = sb; ex = eb; mx = mb;
            sy = sa; ey = ea; my = ma;
        end

        d  = int'(ex) - int'(ey);
        my = (d >= W) ? '0 : (my >> d);
        sum = (sx == sy) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});

        lz    = 0;
        found = 1'b0;
        for (int i = W; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz    = lz + 1;
            end
        end

        norm  = sum << lz;
        e_res = int'(ex) + 1 - lz;

        if (sum == '0)
            result = '0;
        else if (e_res >= EMAX)
            result = {sx, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        else if (e_res <= 0)
            result = {sx, {(I_DATA-1){1'b0}}};
        else
            result = {sx, e_res[I_EXP-1:0], norm[W-1 -: I_MNT]};
    end

endmodule

// File: rtl/fadd_sub_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fadd_sub_arbiter.sv
// Shares one fadd_sub among N_REQ requesters; FADD_SUB_ARB_STATS_EN adds per-requester completion counters.
//   state | meaning
//   IDLE  | arbitrate, accept one request
//   EXEC  | adder runs from operand regs, result captured
//   RESP  | rsp_valid high until rsp_ready
module fadd_sub_arbiter
    import fadd_sub_arb_pkg::*;
#(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1,
    parameter int N_REQ  = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*I_DATA-1:0] req_a,
    input  logic [N_REQ*I_DATA-1:0] req_b,
    input  logic [N_REQ-1:0]        req_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [I_DATA-1:0]       rsp_result
`ifdef FADD_SUB_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_cnt
`endif
);
    state_t              state, state_nxt;
    logic [ID_W-1:0]     last_grant;
    logic [N_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]     arb_id;
    logic                arb_any;
    logic [I_DATA-1:0]   op_a, op_b, fs_result;
    logic                op_sub;
    logic [ID_W-1:0]     op_id;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (last_grant),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    fadd_sub #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_fadd_sub (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .result (fs_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rsp_valid decodes straight from the state flop, so it is glitch-free
    always_comb begin
        req_ready = '0;
        if (state == IDLE) req_ready = arb_gnt;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(N_REQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else begin
            if (state == IDLE && arb_any) begin
                op_a       <= req_a[arb_id*I_DATA +: I_DATA];
                op_b       <= req_b[arb_id*I_DATA +: I_DATA];
                op_sub     <= req_sub[arb_id];
                op_id      <= arb_id;
                last_grant <= arb_id;
            end
            if (state == EXEC) begin
                rsp_result <= fs_result;
                rsp_id     <= op_id;
            end
        end
    end

`ifdef FADD_SUB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stat_cnt <= '0;
        else if (state == RESP && rsp_ready && stat_cnt[rsp_id*STAT_W +: STAT_W] != '1)
            stat_cnt[rsp_id*STAT_W +: STAT_W] <= stat_cnt[rsp_id*STAT_W +: STAT_W] + 1'b1;
    end
`endif

endmodule
